// File: rtl/pixel_sequencer_pkg.sv
// Shared types and constants for the pixel array frame sequencer.
package pixel_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEF_ERASE_CYCLES   = 5;
  localparam int unsigned DEF_EXPOSE_CYCLES  = 255;
  localparam int unsigned DEF_CONVERT_CYCLES = 255;
  localparam int unsigned DEF_READ_CYCLES    = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ0   = 3'd4,
    S_GAP     = 3'd5,
    S_READ1   = 3'd6,
    S_DONE    = 3'd7
  } pix_state_t;

  // Timed states run from N-1 down to 0 inclusive, i.e. N cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pixel_sequencer_if.sv
// Control/status bundle between the frame sequencer and the pixel array / readout.
interface pixel_sequencer_if;
  import pixel_pkg::*;

  logic             START;
  logic             ABORT;
  logic             CONTINUOUS;
  logic             ERASE;
  logic             EXPOSE;
  logic             CONVERT;
  logic             READ0;
  logic             READ1;
  logic             BUSY;
  logic             ROW_VALID;
  logic             ROW_SEL;
  logic             FRAME_DONE;
  logic [CNT_W-1:0] FRAME_CNT;

  modport master (
    input  START, ABORT, CONTINUOUS,
    output ERASE, EXPOSE, CONVERT, READ0, READ1,
           BUSY, ROW_VALID, ROW_SEL, FRAME_DONE, FRAME_CNT
  );

  modport slave (
    output START, ABORT, CONTINUOUS,
    input  ERASE, EXPOSE, CONVERT, READ0, READ1,
           BUSY, ROW_VALID, ROW_SEL, FRAME_DONE, FRAME_CNT
  );

endinterface

// File: rtl/pixel_sequencer_cycle_counter.sv
// Loadable down-counter timing each sequencer state; also predicts next-cycle zero
// so the row-valid strobe can be registered.
module cycle_counter
  import pixel_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_zero_nxt
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                        r_count <= '0;
    else if (i_load)                  r_count <= i_load_val;
    else if (i_dec && r_count != '0)  r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

  always_comb begin
    o_zero_nxt = o_zero;
    if (i_load)     o_zero_nxt = (i_load_val == '0);
    else if (i_dec) o_zero_nxt = (r_count <= CNT_W'(1));
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Frame sequencer: ERASE -> EXPOSE -> CONVERT -> READ0 -> GAP -> READ1 -> DONE,
// one control active at a time, all outputs registered.
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES   = DEF_ERASE_CYCLES,
  parameter int unsigned EXPOSE_CYCLES  = DEF_EXPOSE_CYCLES,
  parameter int unsigned CONVERT_CYCLES = DEF_CONVERT_CYCLES,
  parameter int unsigned READ_CYCLES    = DEF_READ_CYCLES
)(
  input  logic               CLK,
  input  logic               RESET,
  pixel_sequencer_if.master  bus
);

  generate
    if (ERASE_CYCLES   == 0 || ERASE_CYCLES   > 65535 ||
        EXPOSE_CYCLES  == 0 || EXPOSE_CYCLES  > 65535 ||
        CONVERT_CYCLES == 0 || CONVERT_CYCLES > 65535 ||
        READ_CYCLES    == 0 || READ_CYCLES    > 65535) begin : g_bad_cfg
      $error("pixel_sequencer: cycle parameters must be in 1..65535");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LD_ERASE   = cnt_load(ERASE_CYCLES);
  localparam logic [CNT_W-1:0] LD_EXPOSE  = cnt_load(EXPOSE_CYCLES);
  localparam logic [CNT_W-1:0] LD_CONVERT = cnt_load(CONVERT_CYCLES);
  localparam logic [CNT_W-1:0] LD_READ    = cnt_load(READ_CYCLES);

  pix_state_t       r_state, w_nxt;
  logic             w_load, w_dec, w_zero, w_zero_nxt, w_rv_nxt;
  logic [CNT_W-1:0] w_load_val;

  logic             r_erase, r_expose, r_convert, r_read0, r_read1;
  logic             r_busy, r_row_valid, r_row_sel, r_frame_done;
  logic [CNT_W-1:0] r_frame_cnt;

  cycle_counter u_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero),
    .o_zero_nxt (w_zero_nxt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.START) begin
          w_nxt = S_ERASE; w_load = 1'b1; w_load_val = LD_ERASE;
        end
      S_ERASE:
        if (w_zero) begin
          w_nxt = S_EXPOSE; w_load = 1'b1; w_load_val = LD_EXPOSE;
        end else w_dec = 1'b1;
      S_EXPOSE:
        if (w_zero) begin
          w_nxt = S_CONVERT; w_load = 1'b1; w_load_val = LD_CONVERT;
        end else w_dec = 1'b1;
      S_CONVERT:
        if (w_zero) begin
          w_nxt = S_READ0; w_load = 1'b1; w_load_val = LD_READ;
        end else w_dec = 1'b1;
      S_READ0:
        if (w_zero) w_nxt = S_GAP;
        else        w_dec = 1'b1;
      // GAP keeps READ0 and READ1 from ever toggling on the same edge.
      S_GAP: begin
        w_nxt = S_READ1; w_load = 1'b1; w_load_val = LD_READ;
      end
      S_READ1:
        if (w_zero) w_nxt = S_DONE;
        else        w_dec = 1'b1;
      S_DONE:
        if (bus.CONTINUOUS || bus.START) begin
          w_nxt = S_ERASE; w_load = 1'b1; w_load_val = LD_ERASE;
        end else w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (bus.ABORT) begin
      w_nxt      = S_IDLE;
      w_load     = 1'b1;
      w_load_val = '0;
      w_dec      = 1'b0;
    end
  end

  assign w_rv_nxt = (w_nxt == S_READ0 || w_nxt == S_READ1) && w_zero_nxt;

  // Outputs are decoded from the next state so they land in flops aligned with r_state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_convert    <= 1'b0;
      r_read0      <= 1'b0;
      r_read1      <= 1'b0;
      r_busy       <= 1'b0;
      r_row_valid  <= 1'b0;
      r_row_sel    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_erase      <= (w_nxt == S_ERASE);
      r_expose     <= (w_nxt == S_EXPOSE);
      r_convert    <= (w_nxt == S_CONVERT);
      r_read0      <= (w_nxt == S_READ0);
      r_read1      <= (w_nxt == S_READ1);
      r_busy       <= (w_nxt != S_IDLE);
      r_frame_done <= (w_nxt == S_DONE);
      r_row_valid  <= w_rv_nxt;
      if (w_rv_nxt) r_row_sel <= (w_nxt == S_READ1);
      if (r_state == S_DONE && !bus.ABORT) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign bus.ERASE      = r_erase;
  assign bus.EXPOSE     = r_expose;
  assign bus.CONVERT    = r_convert;
  assign bus.READ0      = r_read0;
  assign bus.READ1      = r_read1;
  assign bus.BUSY       = r_busy;
  assign bus.ROW_VALID  = r_row_valid;
  assign bus.ROW_SEL    = r_row_sel;
  assign bus.FRAME_DONE = r_frame_done;
  assign bus.FRAME_CNT  = r_frame_cnt;

endmodule
